mips_regfile_arbiter: RTL and testbench
=======================================

Name: mips_regfile_arbiter

Overview:
- Shares the single 2-read/1-write `mips_registers` file among NUM_REQ requesters, e.g. the datapath controller and the debug/loader port.
- Each requester issues either a read-pair op (rs, rt) or a write op (rd, data) over a valid/ready handshake.
- One op is granted per cycle using round-robin arbitration.
- A requester can lock the file for a bounded burst, e.g. a read-modify-write sequence.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- LOCK_MAX, 4, maximum granted ops per locked burst; must be ≥1.
- ID_W, 3, width of resp_id.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  op present, one bit per requester.
- req_write  in  NUM_REQ  1 = write op, 0 = read-pair op.
- req_lock  in  NUM_REQ  request to keep the grant after this op.
- req_rs  in  NUM_REQ*5  read address 1, packed with requester i at bits [5i+4:5i].
- req_rt  in  NUM_REQ*5  read address 2, packed the same way.
- req_rd  in  NUM_REQ*5  write address, packed the same way.
- req_wdata  in  NUM_REQ*32  write data, packed the same way.
- req_ready  out  NUM_REQ  grant; an op completes in any cycle where valid and ready are both 1.
- resp_valid  out  1  read data valid.
- resp_id  out  ID_W  index of the requester owning the response.
- resp_data_1  out  32  captured read data 1.
- resp_data_2  out  32  captured read data 2.
- rf_read_reg_1  out  5  to register-file read_reg_1.
- rf_read_reg_2  out  5  to register-file read_reg_2.
- rf_write_reg  out  5  to register-file write_reg.
- rf_write_data  out  32  to register-file write_data.
- rf_reg_write  out  1  to register-file signal_reg_write.
- rf_read_data_1  in  32  combinational read data 1 from the register file.
- rf_read_data_2  in  32  combinational read data 2 from the register file.

Behaviour:
- Reset (synchronous):
  - State goes to ARB; round-robin pointer ptr=0; lock_cnt=0; owner=0.
  - resp_valid=0, resp_id=0, resp_data_1/2=0.
  - req_ready=0, all rf_* outputs 0.
  - Reset asserted mid-burst drops the lock. Any op in the reset cycle is not performed, so no write occurs.
- req_ready is combinational from state, ptr, owner and req_valid. At most one bit is set per cycle.
- Ungranted cycle: rf_* outputs are 0 and rf_reg_write=0.
- Read op granted in cycle N:
  - rf_read_reg_1=rs and rf_read_reg_2=rt during N.
  - rf_read_data_1/2 are captured at the end of N.
  - resp_valid=1 for exactly one cycle (N+1) with resp_id=granted index. resp_data holds its value until the next read response.
  - There is no response backpressure.
- Write op granted in cycle N:
  - rf_write_reg=rd, rf_write_data=wdata and rf_reg_write=1 during N; the register file writes at the end of N.
  - rd=0: rf_reg_write is forced to 0 and the handshake still completes ($zero is immutable).
  - No response is generated.
- Read-after-write: a read granted in N+1 returns the data written in N.
- State ARB:
  - Winner w is the first asserted req_valid scanning from ptr upward, wrapping modulo NUM_REQ.
  - On a grant: ptr becomes (w+1) mod NUM_REQ.
  - If req_lock[w]=1 and LOCK_MAX>1: go to LOCKED with owner=w and lock_cnt=1; ptr does not advance.
  - No valid requests: stay in ARB; ptr unchanged.
- State LOCKED:
  - req_valid[owner]=1: grant owner only and increment lock_cnt. Go to ARB with ptr=owner+1 if req_lock[owner]=0 or lock_cnt reaches LOCK_MAX.
  - req_valid[owner]=0: release immediately and arbitrate in the same cycle exactly as in ARB (owner excluded only by its own low valid).
  - Other requesters see req_ready=0 for the whole burst.
- Inputs of an ungranted requester are ignored. A requester must hold its op stable until granted.

Optional Feature:
- MIPS_RF_ARB_STATS_EN defined:
  - Adds output grant_count of width NUM_REQ*16: one saturating 16-bit count per requester, incremented on each completed handshake and cleared by reset.
  - Adds output zero_write_count of width 16, which counts suppressed writes to register 0.
- Undefined: neither output exists and no counter logic is built.

Decomposition:
- Package mips_rf_arb_pkg holds:
  - REG_ADDR_W=5, DATA_W=32, ZERO_REG=5'd0.
  - State enum {ARB, LOCKED}.
- One sub-module, mips_rr_picker: combinational round-robin first-one picker (valid vector, ptr) returning (found, index).

Test Plan:
- Reset, then req0 read rs=1, rt=2 with the file preloaded r1=32'h11, r2=32'h22 → ready0 in cycle N; in N+1 resp_valid=1, resp_id=0, data 32'h11 / 32'h22.
- req0 write rd=3 data 32'hDEADBEEF, then req1 read rs=3 next cycle → rf_reg_write=1 for one cycle; resp_data_1=32'hDEADBEEF.
- req0 and req1 both valid continuously for 6 cycles → grants alternate 0,1,0,1,0,1.
- req1 with lock held for 6 ops while req0 is also valid, LOCK_MAX=4 → req1 granted 4 consecutive cycles, then req0 granted, then req1.
- Write rd=0 data 32'hFFFFFFFF, then read rs=0 → handshake completes, rf_reg_write stays 0, read returns 0. Stats build: zero_write_count=1.
- Assert reset during cycle 2 of a locked burst → no write that cycle; all outputs 0 next cycle; the next grant goes to requester 0.

Source files
------------

// File: rtl/mips_regfile_arbiter_pkg.sv
// mips_rf_arb_pkg: shared constants and types for the register-file arbiter.
//   REG_ADDR_W  register address width (32 MIPS registers)
//   DATA_W      register data width
//   ZERO_REG    address of the hard-wired $zero register
//   arb_state_e arbiter FSM states
package mips_rf_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mips_regfile_arbiter_if.sv
// mips_regfile_arbiter_if: requester-side bus of the register-file arbiter.
//   req_valid/req_write/req_lock  one bit per requester
//   req_rs/req_rt/req_rd          5-bit addresses, requester i at [5i+4:5i]
//   req_wdata                     32-bit write data, requester i at [32i+31:32i]
//   req_ready                     one-hot grant (op completes on valid & ready)
//   resp_valid/resp_id/resp_data_1/resp_data_2  registered read response
// Modports: master (requesters / bench), slave (arbiter).
interface mips_regfile_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 3
);
    import mips_rf_arb_pkg::*;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ-1:0]            req_lock;
    logic [NUM_REQ*REG_ADDR_W-1:0] req_rs;
    logic [NUM_REQ*REG_ADDR_W-1:0] req_rt;
    logic [NUM_REQ*REG_ADDR_W-1:0] req_rd;
    logic [NUM_REQ*DATA_W-1:0]     req_wdata;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          resp_valid;
    logic [ID_W-1:0]               resp_id;
    logic [DATA_W-1:0]             resp_data_1;
    logic [DATA_W-1:0]             resp_data_2;

    modport master (
        output req_valid, req_write, req_lock, req_rs, req_rt, req_rd, req_wdata,
        input  req_ready, resp_valid, resp_id, resp_data_1, resp_data_2
    );

    modport slave (
        input  req_valid, req_write, req_lock, req_rs, req_rt, req_rd, req_wdata,
        output req_ready, resp_valid, resp_id, resp_data_1, resp_data_2
    );

endinterface

// File: rtl/mips_regfile_arbiter_rr_picker.sv
// mips_rr_picker: combinational round-robin first-one picker.
//   valid  in   request vector
//   ptr    in   highest-priority index
//   found  out  at least one valid bit set
//   idx    out  first set bit scanning from ptr upward, wrapping
module mips_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    // Two passes instead of a modulo index: first the bits at or above ptr,
    // then the wrapped-around bits below it.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && valid[i] && (IDX_W'(i) >= ptr)) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && valid[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mips_regfile_arbiter.sv
// mips_regfile_arbiter: shares one 2-read/1-write MIPS register file among
// NUM_REQ requesters, one op per cycle, round-robin with bounded lock bursts.
//   clk, reset         clock, synchronous active-high reset
//   bus (slave)        requester ops, one-hot req_ready, read response
//   rf_read_reg_1/2    register-file read addresses
//   rf_write_reg/data  register-file write port, rf_reg_write enable
//   rf_read_data_1/2   combinational read data from the register file
// Optional build macro MIPS_RF_ARB_STATS_EN adds grant_count (16-bit
// saturating per requester) and zero_write_count (suppressed $zero writes).
//
// state  | meaning
// -------+--------------------------------------------------------------
// ARB    | round-robin among all valid requesters starting at ptr
// LOCKED | owner holds the file; lock_cnt ops granted so far in burst
module mips_regfile_arbiter
    import mips_rf_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int LOCK_MAX = 4,
    parameter int ID_W     = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    mips_regfile_arbiter_if.slave bus,
    output logic [REG_ADDR_W-1:0] rf_read_reg_1,
    output logic [REG_ADDR_W-1:0] rf_read_reg_2,
    output logic [REG_ADDR_W-1:0] rf_write_reg,
    output logic [DATA_W-1:0]     rf_write_data,
    output logic                  rf_reg_write,
    input  logic [DATA_W-1:0]     rf_read_data_1,
    input  logic [DATA_W-1:0]     rf_read_data_2
`ifdef MIPS_RF_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0] grant_count,
    output logic [15:0]           zero_write_count
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             grant;
    logic [IDX_W-1:0] gnt_idx;

    logic                  op_write;
    logic [REG_ADDR_W-1:0] op_rs, op_rt, op_rd;
    logic [DATA_W-1:0]     op_wdata;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    mips_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .valid (bus.req_valid),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB;
            ptr_q      <= '0;
            owner_q    <= '0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        grant      = 1'b0;
        gnt_idx    = owner_q;
        if (reset) begin
            // nothing is granted while reset is asserted
            grant = 1'b0;
        end else if (state_q == LOCKED && bus.req_valid[owner_q]) begin
            grant      = 1'b1;
            gnt_idx    = owner_q;
            lock_cnt_d = lock_cnt_q + CNT_W'(1);
            if (!bus.req_lock[owner_q] || lock_cnt_q == CNT_W'(LOCK_MAX - 1)) begin
                state_d    = ARB;
                ptr_d      = next_idx(owner_q);
                lock_cnt_d = '0;
            end
        end else if (pick_found) begin
            // also the path when a lock owner drops valid: released and
            // re-arbitrated in the same cycle from the pre-burst pointer
            grant   = 1'b1;
            gnt_idx = pick_idx;
            if (bus.req_lock[pick_idx] && LOCK_MAX > 1) begin
                state_d    = LOCKED;
                owner_d    = pick_idx;
                lock_cnt_d = CNT_W'(1);
            end else begin
                state_d    = ARB;
                ptr_d      = next_idx(pick_idx);
                lock_cnt_d = '0;
            end
        end else begin
            state_d    = ARB;
            lock_cnt_d = '0;
        end
    end

    always_comb begin
        op_write = bus.req_write[gnt_idx];
        op_rs    = bus.req_rs[int'(gnt_idx)*REG_ADDR_W +: REG_ADDR_W];
        op_rt    = bus.req_rt[int'(gnt_idx)*REG_ADDR_W +: REG_ADDR_W];
        op_rd    = bus.req_rd[int'(gnt_idx)*REG_ADDR_W +: REG_ADDR_W];
        op_wdata = bus.req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
    end

    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = grant && (gnt_idx == IDX_W'(i));
        end
    end

    always_comb begin
        rf_read_reg_1 = '0;
        rf_read_reg_2 = '0;
        rf_write_reg  = '0;
        rf_write_data = '0;
        rf_reg_write  = 1'b0;
        if (grant) begin
            if (op_write) begin
                rf_write_reg  = op_rd;
                rf_write_data = op_wdata;
                rf_reg_write  = (op_rd != ZERO_REG);
            end else begin
                rf_read_reg_1 = op_rs;
                rf_read_reg_2 = op_rt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.resp_valid  <= 1'b0;
            bus.resp_id     <= '0;
            bus.resp_data_1 <= '0;
            bus.resp_data_2 <= '0;
        end else begin
            bus.resp_valid <= grant && !op_write;
            if (grant && !op_write) begin
                bus.resp_id     <= ID_W'(gnt_idx);
                bus.resp_data_1 <= rf_read_data_1;
                bus.resp_data_2 <= rf_read_data_2;
            end
        end
    end

`ifdef MIPS_RF_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_count      <= '0;
            zero_write_count <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_ready[i] && grant_count[i*16 +: 16] != 16'hFFFF) begin
                    grant_count[i*16 +: 16] <= grant_count[i*16 +: 16] + 16'd1;
                end
            end
            if (grant && op_write && op_rd == ZERO_REG && zero_write_count != 16'hFFFF) begin
                zero_write_count <= zero_write_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mips_regfile_arbiter.sv
module tb_mips_regfile_arbiter;
    import mips_rf_arb_pkg::*;

    localparam int NUM_REQ  = 2;
    localparam int LOCK_MAX = 4;
    localparam int ID_W     = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_regfile_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    logic [4:0]  rf_read_reg_1, rf_read_reg_2, rf_write_reg;
    logic [31:0] rf_write_data, rf_read_data_1, rf_read_data_2;
    logic        rf_reg_write;
`ifdef MIPS_RF_ARB_STATS_EN
    logic [NUM_REQ*16-1:0] grant_count;
    logic [15:0]           zero_write_count;
`endif

    mips_regfile_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .LOCK_MAX (LOCK_MAX),
        .ID_W     (ID_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .rf_read_reg_1  (rf_read_reg_1),
        .rf_read_reg_2  (rf_read_reg_2),
        .rf_write_reg   (rf_write_reg),
        .rf_write_data  (rf_write_data),
        .rf_reg_write   (rf_reg_write),
        .rf_read_data_1 (rf_read_data_1),
        .rf_read_data_2 (rf_read_data_2)
`ifdef MIPS_RF_ARB_STATS_EN
        ,
        .grant_count      (grant_count),
        .zero_write_count (zero_write_count)
`endif
    );

    // register-file model: combinational read, write at clock edge
    logic [31:0] mem [32];
    logic        mem_init;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
            mem[1] <= 32'h11;
            mem[2] <= 32'h22;
        end else if (rf_reg_write && rf_write_reg != 5'd0) begin
            mem[rf_write_reg] <= rf_write_data;
        end
    end
    assign rf_read_data_1 = (rf_read_reg_1 == 5'd0) ? 32'h0 : mem[rf_read_reg_1];
    assign rf_read_data_2 = (rf_read_reg_2 == 5'd0) ? 32'h0 : mem[rf_read_reg_2];

    typedef struct {
        logic [ID_W-1:0] id;
        logic [31:0]     d1;
        logic [31:0]     d2;
    } resp_t;
    resp_t sb_q[$];

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input int id, input logic [31:0] d1, input logic [31:0] d2);
        resp_t r;
        r.id = ID_W'(id);
        r.d1 = d1;
        r.d2 = d2;
        sb_q.push_back(r);
    endtask

    // response monitor: every response pops the oldest expected entry
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.resp_valid === 1'b1) begin
            vectors++;
            assert (sb_q.size() > 0) else begin
                miscompares++;
                $error("FAIL sb_unexpected_resp observed=%0d expected=%0d", 1, 0);
            end
            if (sb_q.size() > 0) begin
                resp_t r;
                r = sb_q.pop_front();
                check("resp_id",     64'(bus.resp_id),     64'(r.id));
                check("resp_data_1", 64'(bus.resp_data_1), 64'(r.d1));
                check("resp_data_2", 64'(bus.resp_data_2), 64'(r.d2));
            end
        end
    end

    task automatic clear_req();
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_lock  = '0;
        bus.req_rs    = '0;
        bus.req_rt    = '0;
        bus.req_rd    = '0;
        bus.req_wdata = '0;
    endtask

    task automatic set_read(input int r, input logic [4:0] rs, input logic [4:0] rt, input logic lock);
        bus.req_valid[r]       = 1'b1;
        bus.req_write[r]       = 1'b0;
        bus.req_lock[r]        = lock;
        bus.req_rs[r*5 +: 5]   = rs;
        bus.req_rt[r*5 +: 5]   = rt;
    endtask

    task automatic set_write(input int r, input logic [4:0] rd, input logic [31:0] d, input logic lock);
        bus.req_valid[r]        = 1'b1;
        bus.req_write[r]        = 1'b1;
        bus.req_lock[r]         = lock;
        bus.req_rd[r*5 +: 5]    = rd;
        bus.req_wdata[r*32 +: 32] = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp_rdy;

    initial begin
        reset    = 1'b1;
        mem_init = 1'b1;
        clear_req();
        set_read(0, 5'd1, 5'd2, 1'b0);
        @(negedge clk);
        check("ready_in_reset", 64'(bus.req_ready), 64'd0);
        next_cycle();
        mem_init = 1'b0;
        next_cycle();
        reset = 1'b0;
        clear_req();

        // reset state
        @(negedge clk);
        check("rst_ready",      64'(bus.req_ready),   64'd0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_id",    64'(bus.resp_id),     64'd0);
        check("rst_resp_data",  {bus.resp_data_1, bus.resp_data_2}, 64'd0);
        check("rst_rf_out", {rf_read_reg_1, rf_read_reg_2, rf_write_reg, rf_reg_write, rf_write_data}, 64'd0);
        next_cycle();

        // single read by req0
        set_read(0, 5'd1, 5'd2, 1'b0);
        @(negedge clk);
        check("rd_ready",  64'(bus.req_ready), 64'b01);
        check("rd_addr",   {rf_read_reg_1, rf_read_reg_2}, {5'd1, 5'd2});
        check("rd_no_wr",  64'(rf_reg_write), 64'd0);
        push(0, 32'h11, 32'h22);
        next_cycle();
        clear_req();
        @(negedge clk);
        check("rd_resp_valid", 64'(bus.resp_valid), 64'd1);
        check("rd_ready_idle", 64'(bus.req_ready),  64'd0);
        next_cycle();
        @(negedge clk);
        check("rd_resp_one_cycle", 64'(bus.resp_valid),  64'd0);
        check("rd_resp_hold",      64'(bus.resp_data_1), 64'h11);
        next_cycle();

        // write then read-after-write from another requester (ptr=1)
        set_write(0, 5'd3, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        check("wr_ready",   64'(bus.req_ready), 64'b01);
        check("wr_port",    {rf_reg_write, rf_write_reg, rf_write_data}, {1'b1, 5'd3, 32'hDEADBEEF});
        next_cycle();
        clear_req();
        set_read(1, 5'd3, 5'd1, 1'b0);
        @(negedge clk);
        check("raw_ready",  64'(bus.req_ready), 64'b10);
        check("raw_no_wr",  64'(rf_reg_write),  64'd0);
        push(1, 32'hDEADBEEF, 32'h11);
        next_cycle();
        clear_req();
        @(negedge clk);
        check("raw_resp_valid", 64'(bus.resp_valid), 64'd1);
        next_cycle();

        // both requesting continuously: strict alternation from ptr=0
        for (int k = 0; k < 6; k++) begin
            set_read(0, 5'd1, 5'd2, 1'b0);
            set_read(1, 5'd3, 5'd0, 1'b0);
            exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            check($sformatf("rr_ready_%0d", k), 64'(bus.req_ready), 64'(exp_rdy));
            if (exp_rdy == 2'b01) push(0, 32'h11, 32'h22);
            else                  push(1, 32'hDEADBEEF, 32'h0);
            next_cycle();
        end
        clear_req();
        next_cycle();

        // move ptr to 1 with a single req0 write
        set_write(0, 5'd4, 32'h5, 1'b0);
        @(negedge clk);
        check("pre_lock_ready", 64'(bus.req_ready), 64'b01);
        next_cycle();
        clear_req();

        // req1 locked burst of 6 ops against a busy req0
        for (int c = 0; c < 8; c++) begin
            clear_req();
            set_read(0, 5'd3, 5'd4, 1'b0);
            if (c < 7) set_read(1, 5'd1, 5'd2, 1'b1);
            exp_rdy = (c == 4 || c == 7) ? 2'b01 : 2'b10;
            @(negedge clk);
            check($sformatf("lock_ready_%0d", c), 64'(bus.req_ready), 64'(exp_rdy));
            if (exp_rdy == 2'b01) push(0, 32'hDEADBEEF, 32'h5);
            else                  push(1, 32'h11, 32'h22);
            next_cycle();
        end
        clear_req();
        next_cycle();

        // write to $zero is suppressed, read of $zero returns 0
        set_write(0, 5'd0, 32'hFFFFFFFF, 1'b0);
        @(negedge clk);
        check("zw_ready",    64'(bus.req_ready), 64'b01);
        check("zw_no_write", 64'(rf_reg_write),  64'd0);
        next_cycle();
        clear_req();
        set_read(0, 5'd0, 5'd3, 1'b0);
        @(negedge clk);
        check("zr_ready", 64'(bus.req_ready), 64'b01);
        push(0, 32'h0, 32'hDEADBEEF);
        next_cycle();
        clear_req();
        @(negedge clk);
        check("zr_resp_valid", 64'(bus.resp_valid), 64'd1);
`ifdef MIPS_RF_ARB_STATS_EN
        check("zero_write_count", 64'(zero_write_count), 64'd1);
`endif
        next_cycle();

        // reset in the second cycle of a locked burst (ptr=1)
        set_write(1, 5'd5, 32'h1, 1'b1);
        set_read(0, 5'd5, 5'd6, 1'b0);
        @(negedge clk);
        check("rl_ready0", 64'(bus.req_ready), 64'b10);
        check("rl_write0", {rf_reg_write, rf_write_reg}, {1'b1, 5'd5});
        next_cycle();
        set_write(1, 5'd6, 32'h66, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("rl_ready_rst", 64'(bus.req_ready), 64'd0);
        check("rl_no_write",  64'(rf_reg_write),  64'd0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("rl_post_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rl_post_resp_id",    64'(bus.resp_id),    64'd0);
        check("rl_post_resp_data",  {bus.resp_data_1, bus.resp_data_2}, 64'd0);
        check("rl_mem6_unwritten",  64'(mem[6]), 64'd0);
        check("rl_next_grant",      64'(bus.req_ready), 64'b01);
        push(0, 32'h1, 32'h0);
        next_cycle();
        clear_req();
        next_cycle();
        next_cycle();

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
